// File: rtl/alu_result_queue.sv
// Result FIFO behind the combinational ALU: buffers {y, flags, op, tag}, tracks sticky C/V and an accept counter.
// Optional flag cross-check is compiled in with `define ALU_RESULT_CHECK_EN (flag_err tied 0 otherwise).
module alu_result_queue #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_y,
    input  logic             in_z,
    input  logic             in_n,
    input  logic             in_c,
    input  logic             in_v,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [3:0]       out_flags,
    output logic [2:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             sticky_c,
    output logic             sticky_v,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             flag_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      y;
        logic [3:0]       flags;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head_reg, head_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]     count_reg, count_next;
    logic            sticky_c_reg, sticky_c_next;
    logic            sticky_v_reg, sticky_v_next;
    logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next;
    logic            push, pop;

    assign in_entry  = '{y: in_y, flags: {in_z, in_n, in_c, in_v}, op: in_op, tag: in_tag};
    assign in_ready  = (count_reg != FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        head_next     = head_reg;
        sticky_c_next = sticky_c_reg;
        sticky_v_next = sticky_v_reg;
        acc_cnt_next  = acc_cnt_reg;

        if (push) begin
            wr_ptr_next  = wr_ptr_reg + 1'b1;
            acc_cnt_next = acc_cnt_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        // Head register preloads the next head; a push landing in the head slot bypasses the array.
        if (count_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = in_entry;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end

        if (sticky_clr) begin
            sticky_c_next = 1'b0;
            sticky_v_next = 1'b0;
        end
        if (push) begin
            sticky_c_next = sticky_c_next | (in_c & (in_op == 3'b000 || in_op == 3'b001));
            sticky_v_next = sticky_v_next | in_v;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            sticky_c_reg <= 1'b0;
            sticky_v_reg <= 1'b0;
            acc_cnt_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            head_reg     <= head_next;
            sticky_c_reg <= sticky_c_next;
            sticky_v_reg <= sticky_v_next;
            acc_cnt_reg  <= acc_cnt_next;
        end
    end

    assign out_y     = head_reg.y;
    assign out_flags = head_reg.flags;
    assign out_op    = head_reg.op;
    assign out_tag   = head_reg.tag;
    assign sticky_c  = sticky_c_reg;
    assign sticky_v  = sticky_v_reg;
    assign acc_cnt   = acc_cnt_reg;

`ifdef ALU_RESULT_CHECK_EN
    logic flag_err_reg, flag_err_next, flag_mismatch;

    assign flag_mismatch = ((in_y == 32'd0) != in_z) || (in_y[31] != in_n);

    always_comb begin
        flag_err_next = flag_err_reg;
        if (sticky_clr) begin
            flag_err_next = 1'b0;
        end
        if (push && flag_mismatch) begin
            flag_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_err_reg <= 1'b0;
        end else begin
            flag_err_reg <= flag_err_next;
        end
    end

    assign flag_err = flag_err_reg;
`else
    assign flag_err = 1'b0;
`endif

endmodule
